spi_cmd_dispatch: RTL and testbench

Parametrised command decoder between `spi_slave` and the fabric. It replaces the fixed 4×24-bit top-level decoder. Each received frame carries an 8-bit opcode in bits [7:0] and a PAYLOAD_W-bit operand above it. The block executes register, LED and vector commands, and returns read data through the `spi_slave` write port. Over the previous decoder it adds:
- generic vector depth and width
- explicit pointer seek
- a status/error readback
- lossless queuing of a command that arrives mid-burst

---
 rtl/spi_cmd_pkg.sv | 25 ++
 rtl/spi_vec_regfile.sv | 31 +++
 rtl/spi_cmd_dispatch.sv | 194 +++++++++++++++++++
 tb/tb_spi_cmd_dispatch.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_cmd_pkg.sv
// Shared opcode map, FSM encoding and status-word layout for the SPI command dispatcher.
package spi_cmd_pkg;

    localparam logic [7:0] OP_NOP       = 8'd0;
    localparam logic [7:0] OP_INIT      = 8'd1;
    localparam logic [7:0] OP_WR_INV    = 8'd2;
    localparam logic [7:0] OP_RD_INV    = 8'd3;
    localparam logic [7:0] OP_WR_LEDS   = 8'd4;
    localparam logic [7:0] OP_RD_LEDS   = 8'd5;
    localparam logic [7:0] OP_WR_VEC    = 8'd6;
    localparam logic [7:0] OP_RD_VEC    = 8'd7;
    localparam logic [7:0] OP_SET_PTR   = 8'd8;
    localparam logic [7:0] OP_RD_STATUS = 8'd9;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_SEND = 2'd2
    } state_t;

    localparam int         STATUS_ERR_LSB = 0;
    localparam int         STATUS_PTR_LSB = 8;
    localparam logic [7:0] ERR_MAX        = 8'd255;

endpackage

// File: rtl/spi_vec_regfile.sv
// Vector storage: one synchronous write port, one combinational read port,
// synchronous whole-array clear.
module spi_vec_regfile #(
    parameter int PAYLOAD_W = 24,
    parameter int VEC_DEPTH = 4,
    parameter int PTR_W     = 2
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic                 wr_en,
    input  logic [PTR_W-1:0]     wr_addr,
    input  logic [PAYLOAD_W-1:0] wr_data,
    input  logic [PTR_W-1:0]     rd_addr,
    output logic [PAYLOAD_W-1:0] rd_data
);

    logic [PAYLOAD_W-1:0] mem [VEC_DEPTH];

    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < VEC_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/spi_cmd_dispatch.sv
// Decodes spi_slave frames ({operand, opcode}) into register, LED and vector
// commands and returns read data through the spi_slave write port.
module spi_cmd_dispatch
    import spi_cmd_pkg::*;
#(
    parameter int PAYLOAD_W = 24,
    parameter int VEC_DEPTH = 4,
    parameter int LED_W     = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   rx_valid,
    input  logic [PAYLOAD_W+7:0]   rx_data,
    output logic                   rx_ack,
    input  logic                   tx_free,
    output logic                   tx_en,
    output logic [PAYLOAD_W-1:0]   tx_data,
    output logic [LED_W-1:0]       led,
    output logic                   busy
);

    localparam int PTR_W = $clog2(VEC_DEPTH);
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(VEC_DEPTH - 1);

    state_t                 state, state_nxt;
    logic                   rx_valid_q;
    logic                   pending;
    logic [PAYLOAD_W+7:0]   pend_frame;
    logic [7:0]             cmd_op;
    logic [PAYLOAD_W-1:0]   cmd_arg;
    logic [PTR_W-1:0]       ptr;
    logic [PTR_W-1:0]       idx;
    logic [PAYLOAD_W-1:0]   inv_reg;
    logic [7:0]             err_cnt;

    logic                   rx_rise;
    logic                   overrun;
    logic                   capture;
    logic                   fire;
    logic [PAYLOAD_W-1:0]   fire_data;
    logic                   init_cmd;
    logic                   wr_inv;
    logic                   wr_leds;
    logic                   vec_wr;
    logic                   ptr_load;
    logic                   op_err;
    logic                   can_send;
    logic [PAYLOAD_W-1:0]   status_word;
    logic [PAYLOAD_W-1:0]   vec_rd_data;
    logic [PTR_W-1:0]       vec_rd_addr;

    assign rx_rise  = rx_valid & ~rx_valid_q;
    // A frame arriving while one is still queued is dropped, unless the queued
    // one is being taken this very cycle.
    assign overrun  = rx_rise & pending & ~capture;
    // Waiting one idle cycle after every strobe covers the spi_slave free-flag lag.
    assign can_send = tx_free & ~tx_en;
    assign rx_ack   = capture;
    assign busy     = (state != ST_IDLE);

    always_comb begin
        status_word = '0;
        status_word[STATUS_ERR_LSB +: 8]     = err_cnt;
        status_word[STATUS_PTR_LSB +: PTR_W] = ptr;
    end

    assign vec_rd_addr = (state == ST_SEND) ? idx : ptr;

    spi_vec_regfile #(
        .PAYLOAD_W (PAYLOAD_W),
        .VEC_DEPTH (VEC_DEPTH),
        .PTR_W     (PTR_W)
    ) u_vec (
        .clk     (clk),
        .clr     (reset | init_cmd),
        .wr_en   (vec_wr),
        .wr_addr (ptr),
        .wr_data (cmd_arg),
        .rd_addr (vec_rd_addr),
        .rd_data (vec_rd_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        fire      = 1'b0;
        fire_data = '0;
        init_cmd  = 1'b0;
        wr_inv    = 1'b0;
        wr_leds   = 1'b0;
        vec_wr    = 1'b0;
        ptr_load  = 1'b0;
        op_err    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pending) begin
                    capture   = 1'b1;
                    state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                state_nxt = ST_IDLE;
                case (cmd_op)
                    OP_NOP:     ;
                    OP_INIT:    init_cmd = 1'b1;
                    OP_WR_INV:  wr_inv   = 1'b1;
                    OP_WR_LEDS: wr_leds  = 1'b1;
                    OP_WR_VEC:  vec_wr   = 1'b1;
                    OP_SET_PTR: begin
                        if (cmd_arg < PAYLOAD_W'(VEC_DEPTH)) ptr_load = 1'b1;
                        else                                 op_err   = 1'b1;
                    end
                    OP_RD_INV, OP_RD_LEDS, OP_RD_STATUS: begin
                        if (can_send) begin
                            fire = 1'b1;
                            if (cmd_op == OP_RD_INV)       fire_data = inv_reg;
                            else if (cmd_op == OP_RD_LEDS) fire_data = PAYLOAD_W'(led);
                            else                           fire_data = status_word;
                        end else begin
                            state_nxt = ST_EXEC;
                        end
                    end
                    OP_RD_VEC:  state_nxt = ST_SEND;
                    default:    op_err = 1'b1;
                endcase
            end
            ST_SEND: begin
                if (can_send) begin
                    fire      = 1'b1;
                    fire_data = vec_rd_data;
                    if (idx == LAST_IDX) state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_valid_q <= 1'b0;
            pending    <= 1'b0;
            pend_frame <= '0;
            cmd_op     <= '0;
            cmd_arg    <= '0;
            ptr        <= '0;
            idx        <= '0;
            inv_reg    <= '0;
            led        <= '0;
            err_cnt    <= '0;
            tx_en      <= 1'b0;
            tx_data    <= '0;
        end else begin
            rx_valid_q <= rx_valid;

            if (rx_rise)      pending <= 1'b1;
            else if (capture) pending <= 1'b0;
            if (rx_rise && (!pending || capture)) pend_frame <= rx_data;

            if (capture) begin
                cmd_op  <= pend_frame[7:0];
                cmd_arg <= pend_frame[PAYLOAD_W+7:8];
            end

            tx_en <= fire;
            if (fire) tx_data <= fire_data;

            if (fire && state == ST_SEND) begin
                idx <= (idx == LAST_IDX) ? '0 : idx + PTR_W'(1);
            end

            if (init_cmd) begin
                ptr     <= '0;
                inv_reg <= '0;
                led     <= '0;
                err_cnt <= '0;
            end else begin
                if (wr_inv)  inv_reg <= ~cmd_arg;
                if (wr_leds) led     <= cmd_arg[LED_W-1:0];
                if (vec_wr)  ptr     <= (ptr == LAST_IDX) ? '0 : ptr + PTR_W'(1);
                if (ptr_load) ptr    <= cmd_arg[PTR_W-1:0];
                if ((op_err || overrun) && err_cnt != ERR_MAX) err_cnt <= err_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_spi_cmd_dispatch.sv
// Randomised bench for spi_cmd_dispatch with a queue-based command model and literal anchors.
module tb_spi_cmd_dispatch;

    localparam int DEPTH = 4;

    logic        clk;
    logic        reset;
    logic        rx_valid;
    logic [31:0] rx_data;
    logic        rx_ack;
    logic        tx_free;
    logic        tx_en;
    logic [23:0] tx_data;
    logic [2:0]  led;
    logic        busy;

    spi_cmd_dispatch #(.PAYLOAD_W(24), .VEC_DEPTH(DEPTH), .LED_W(3)) dut (
        .clk      (clk),
        .reset    (reset),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .rx_ack   (rx_ack),
        .tx_free  (tx_free),
        .tx_en    (tx_en),
        .tx_data  (tx_data),
        .led      (led),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // ---------------- reference model ----------------
    logic [23:0] m_vec [DEPTH];
    int          m_ptr;
    logic [23:0] m_inv;
    logic [2:0]  m_led;
    int          m_err;
    logic [23:0] exp_q [$];
    int          n_exp_acks = 0;
    int          n_acks     = 0;

    function automatic void m_clear();
        for (int i = 0; i < DEPTH; i++) m_vec[i] = '0;
        m_ptr = 0;
        m_inv = '0;
        m_led = '0;
        m_err = 0;
    endfunction

    function automatic void m_err_inc();
        if (m_err < 255) m_err++;
    endfunction

    function automatic void m_apply(input logic [7:0] op, input logic [23:0] arg);
        case (op)
            8'd0: ;
            8'd1: m_clear();
            8'd2: m_inv = ~arg;
            8'd3: exp_q.push_back(m_inv);
            8'd4: m_led = arg[2:0];
            8'd5: exp_q.push_back({21'd0, m_led});
            8'd6: begin
                m_vec[m_ptr] = arg;
                m_ptr = (m_ptr + 1) % DEPTH;
            end
            8'd7: for (int i = 0; i < DEPTH; i++) exp_q.push_back(m_vec[i]);
            8'd8: begin
                if (int'(arg) < DEPTH) m_ptr = int'(arg);
                else m_err_inc();
            end
            8'd9: exp_q.push_back(24'(m_ptr * 256 + m_err));
            default: m_err_inc();
        endcase
        n_exp_acks++;
    endfunction

    // ---------------- compare process ----------------
    logic [23:0] last_tx  = '0;
    logic        prev_en  = 1'b0;
    logic        prev_free = 1'b0;

    always @(negedge clk) begin
        if (tx_en) begin
            chk("tx_free_before_strobe", 32'(prev_free), 32'd1);
            chk("strobe_spacing", 32'(prev_en), 32'd0);
            if (exp_q.size() == 0) begin
                chk("unexpected_strobe", 32'(tx_data), 32'hDEAD_BEEF);
            end else begin
                chk("tx_data", 32'(tx_data), 32'(exp_q.pop_front()));
            end
            last_tx = tx_data;
        end else begin
            chk("tx_data_hold", 32'(tx_data), 32'(last_tx));
        end
        if (rx_ack) begin
            chk("ack_only_when_idle", 32'(busy), 32'd0);
            n_acks++;
        end
        prev_en   = tx_en;
        prev_free = tx_free;
        if (reset) begin
            last_tx = '0;
            prev_en = 1'b0;
        end
    end

    // ---------------- tx_free driver ----------------
    int tx_mode = 0;   // 0: always free, 1: random, 2: held busy
    initial begin
        tx_free = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (tx_mode)
                0:       tx_free = 1'b1;
                1:       tx_free = 1'($urandom_range(0, 1));
                default: tx_free = 1'b0;
            endcase
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_ack(input string name);
        int t = 0;
        while (t < 3000) begin
            @(negedge clk);
            t++;
            if (rx_ack) break;
        end
        if (t >= 3000) chk(name, 32'd0, 32'd1);
    endtask

    task automatic send(input logic [7:0] op, input logic [23:0] arg);
        @(posedge clk);
        #1;
        rx_data  = {arg, op};
        rx_valid = 1'b1;
        wait_ack("ack_timeout");
        m_apply(op, arg);
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        @(posedge clk);
    endtask

    task automatic wait_idle();
        int t = 0;
        while (t < 3000) begin
            @(negedge clk);
            t++;
            if (!busy && exp_q.size() == 0 && !tx_en) break;
        end
        if (t >= 3000) chk("idle_timeout", 32'd0, 32'd1);
    endtask

    logic [23:0] burst_w   [DEPTH];
    int          burst_cyc [DEPTH];

    task automatic capture_burst();
        int seen = 0;
        int t = 0;
        while (seen < DEPTH && t < 3000) begin
            @(negedge clk);
            t++;
            if (tx_en) begin
                burst_w[seen]   = tx_data;
                burst_cyc[seen] = t;
                seen++;
            end
        end
        if (seen < DEPTH) chk("burst_timeout", 32'(seen), 32'(DEPTH));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int cnt;
        int t;
        logic [7:0]  op;
        logic [23:0] arg;

        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = '0;
        m_clear();
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("reset_rx_ack",  32'(rx_ack),  32'd0);
        chk("reset_tx_en",   32'(tx_en),   32'd0);
        chk("reset_tx_data", 32'(tx_data), 32'd0);
        chk("reset_led",     32'(led),     32'd0);
        chk("reset_busy",    32'(busy),    32'd0);

        // basic register paths
        send(8'd2, 24'h00F0F0);
        send(8'd3, 24'h0);
        wait_idle();
        chk("rd_inv_literal", 32'(last_tx), 32'h00FF0F0F);
        send(8'd4, 24'h000005);
        wait_idle();
        chk("led_literal", 32'(led), 32'd5);
        send(8'd5, 24'h0);
        wait_idle();
        chk("rd_leds_literal", 32'(last_tx), 32'h5);

        // vector write with wrap, full-rate burst
        send(8'd6, 24'h11);
        send(8'd6, 24'h22);
        send(8'd6, 24'h33);
        send(8'd6, 24'h44);
        send(8'd6, 24'h55);
        send(8'd7, 24'h0);
        capture_burst();
        chk("burst_w0", 32'(burst_w[0]), 32'h55);
        chk("burst_w1", 32'(burst_w[1]), 32'h22);
        chk("burst_w2", 32'(burst_w[2]), 32'h33);
        chk("burst_w3", 32'(burst_w[3]), 32'h44);
        for (int i = 1; i < DEPTH; i++) chk("burst_gap", 32'(burst_cyc[i] - burst_cyc[i-1]), 32'd2);
        @(negedge clk);
        chk("busy_after_burst", 32'(busy), 32'd0);
        wait_idle();

        // back-pressure
        tx_mode = 2;
        send(8'd7, 24'h0);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (tx_en) cnt++;
        end
        chk("no_strobe_while_blocked", 32'(cnt), 32'd0);
        tx_mode = 1;
        wait_idle();

        // command arriving mid-burst
        send(8'd7, 24'h0);
        send(8'd9, 24'h0);
        wait_idle();
        chk("status_after_burst", 32'(last_tx), 32'h000100);
        tx_mode = 0;

        // errors
        send(8'd8, 24'd4);
        send(8'd9, 24'h0);
        wait_idle();
        chk("status_bad_ptr", 32'(last_tx), 32'h000101);
        send(8'd8, 24'd2);
        send(8'd9, 24'h0);
        wait_idle();
        chk("status_set_ptr", 32'(last_tx), 32'h000201);

        // overrun: second edge while the first frame is still queued
        tx_mode = 2;
        send(8'd7, 24'h0);
        @(posedge clk); #1 rx_data = {24'h2, 8'd4}; rx_valid = 1'b1;
        @(posedge clk); #1 rx_valid = 1'b0;
        @(posedge clk); #1 rx_data = {24'h7, 8'd4}; rx_valid = 1'b1;
        @(posedge clk); #1 rx_valid = 1'b0;
        tx_mode = 1;
        wait_ack("overrun_ack_timeout");
        m_apply(8'd4, 24'h2);
        m_err_inc();
        wait_idle();
        tx_mode = 0;
        send(8'd9, 24'h0);
        wait_idle();
        chk("status_overrun", 32'(last_tx), 32'h000202);
        chk("led_after_overrun", 32'(led), 32'd2);

        for (int i = 0; i < 300; i++) send(8'hAA, 24'(i));
        send(8'd9, 24'h0);
        wait_idle();
        chk("status_saturated", 32'(last_tx), 32'h0002FF);

        send(8'd1, 24'h0);
        send(8'd9, 24'h0);
        wait_idle();
        chk("status_after_init", 32'(last_tx), 32'h0);
        send(8'd7, 24'h0);
        wait_idle();

        // randomised commands against the model
        for (int i = 0; i < 80; i++) begin
            op  = 8'($urandom_range(0, 11));
            arg = 24'($urandom);
            if (op == 8'd8)  arg = 24'($urandom_range(0, 5));
            if (op == 8'd11) op  = 8'($urandom_range(10, 255));
            tx_mode = int'($urandom_range(0, 1));
            send(op, arg);
            if ($urandom_range(0, 3) == 0) wait_idle();
        end
        tx_mode = 0;
        wait_idle();

        // reset in the middle of a burst
        send(8'd4, 24'h3);
        send(8'd6, 24'hABCDEF);
        send(8'd6, 24'h123456);
        send(8'd7, 24'h0);
        cnt = 0;
        t = 0;
        while (cnt < 2 && t < 3000) begin
            @(negedge clk);
            t++;
            if (tx_en) cnt++;
        end
        if (cnt < 2) chk("reset_burst_timeout", 32'(cnt), 32'd2);
        @(posedge clk);
        #1 reset = 1'b1;
        exp_q.delete();
        m_clear();
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("post_reset_led",   32'(led),   32'd0);
        chk("post_reset_busy",  32'(busy),  32'd0);
        chk("post_reset_tx_en", 32'(tx_en), 32'd0);
        repeat (10) @(negedge clk);
        send(8'd7, 24'h0);
        capture_burst();
        for (int i = 0; i < DEPTH; i++) chk("post_reset_vec", 32'(burst_w[i]), 32'd0);
        wait_idle();

        chk("ack_count", 32'(n_acks), 32'(n_exp_acks));
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
